instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the 4-bit processor datapath.
- Fetches 16-bit instructions from a synchronous instruction ROM and decodes them.
- Drives register-file addresses, the ALU opcode, memory read/write strobes and the register write-back enable through fixed FSM phases.
- Owns the program counter and replaces the free-running per-clock opcode feed in the top-level processor.

Parameters:
- PC_W, 4, program counter width (instruction ROM depth = 2^PC_W).
- MEM_TIMEOUT, 7, maximum cycles spent waiting in MEM for mem_ack before entering FAULT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; starts execution from IDLE.
- step  in  1  single-cycle pulse; used only when SEQ_STEP_EN is defined.
- imem_addr  out  PC_W  instruction ROM address (= pc).
- imem_data  in  16  ROM data, valid one cycle after imem_addr: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm.
- opcode  out  4  ALU/control opcode of the current instruction.
- read_reg1  out  4  rs field.
- read_reg2  out  4  rt field.
- write_reg  out  4  rd field.
- reg_write  out  1  one-cycle write-back enable.
- mem_to_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- mem_read  out  1  memory read strobe, held until mem_ack.
- mem_write  out  1  memory write strobe, held until mem_ack.
- mem_ack  in  1  memory completion.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
- Reset values: pc=0, state=IDLE, all outputs 0. Reset is honoured in any state, including mid-MEM; no strobe survives it.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE -> FETCH when run=1.
- FETCH: imem_addr=pc; next state DECODE. ROM data is valid at DECODE.
- DECODE: latch imem_data into the instruction register. opcode, read_reg1, read_reg2 and write_reg come from the IR and are stable from the cycle after DECODE until the next DECODE.
- Next state after DECODE is EXEC for every opcode except HALT (-> HALT).
- EXEC, by opcode:
  - ALU ops (ADD 0000, SUB 0001, AND 0010, OR 0011) -> WB.
  - LW (0100) and SW (0101) -> MEM.
  - BEQ (0110): if alu_zero=1, pc <= pc + rt (modulo 2^PC_W, wraps); else pc <= pc+1. Then -> FETCH.
  - JMP (0111): pc <= rt; -> FETCH.
  - NOP (1110) and undefined opcodes: pc+1; -> FETCH.
- MEM:
  - mem_read=1 for LW, or mem_write=1 for SW, held each cycle until mem_ack=1.
  - On ack: LW -> WB; SW -> pc+1, -> FETCH.
  - A wait counter increments each cycle without ack. If MEM_TIMEOUT cycles pass without ack -> FAULT; strobes drop that cycle.
  - mem_ack outside MEM is ignored.
- WB: reg_write=1 for exactly one cycle; mem_to_reg=1 iff LW. pc <= pc+1 (wraps 15 -> 0); -> FETCH.
- Latency: ALU op 4 cycles; BEQ/JMP/NOP 3 cycles; LW 5 cycles + wait; SW 4 cycles + wait.
- HALT and FAULT are sticky; only reset exits them. run is ignored outside IDLE.
- reg_write, mem_read and mem_write are never asserted simultaneously.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined: FETCH advances only on a cycle with step=1, otherwise holds, so exactly one instruction executes per step pulse. A step arriving in any other state is dropped.
- Undefined: step is ignored and the sequencer free-runs.

Decomposition:
- Package seq_pkg: opcode localparams (OP_ADD … OP_HALT), state enum encoding, instruction field bit positions.
- One natural sub-module, seq_decode: combinational opcode -> class (alu/load/store/branch/jump/nop/halt).
- PC and FSM stay in instr_sequencer.

Test Plan:
- Reset then run=1, ROM[0]=ADD r3,r1,r2 (0x0312) -> read_reg1=1, read_reg2=2 after DECODE; reg_write=1, write_reg=3 in cycle 4; pc=1.
- LW r4,[r5] with mem_ack after 2 wait cycles -> mem_read high 3 cycles, then reg_write=1 with mem_to_reg=1, pc+1.
- SW with mem_ack never asserted -> strobe drops, fault=1 after 7 MEM cycles; stays until reset.
- BEQ rt=3 at pc=14, alu_zero=1 -> pc wraps to 1. Same instruction with alu_zero=0 -> pc=15.
- HALT at pc=2 -> halted=1 with no further reg_write/mem strobes; reset asserted mid-LW clears mem_read the next cycle and returns pc=0.
- SEQ_STEP_EN defined: three step pulses spaced 10 cycles apart -> exactly three instructions retire; pc=3.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer.
// Opcodes, FSM state codes, instruction fields.
package seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_NOP,
    CL_HALT
  } op_class_e;

endpackage

// File: rtl/seq_decode.sv
// Opcode classifier for the sequencer FSM.
// Undefined opcodes fall into the NOP class.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] op,
  output op_class_e  cls
);

  // map each opcode onto the FSM path it takes
  always_comb begin
    cls = CL_NOP;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB) ||
      (op == OP_AND) || (op == OP_OR):
        cls = CL_ALU;
      (op == OP_LW):   cls = CL_LOAD;
      (op == OP_SW):   cls = CL_STORE;
      (op == OP_BEQ):  cls = CL_BRANCH;
      (op == OP_JMP):  cls = CL_JUMP;
      (op == OP_HALT): cls = CL_HALT;
      default:         cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer.
// Optional single-step mode: define SEQ_STEP_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W        = 4,
  parameter int MEM_TIMEOUT = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [3:0]      opcode,
  output logic [3:0]      read_reg1,
  output logic [3:0]      read_reg2,
  output logic [3:0]      write_reg,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write,
  input  logic            mem_ack,
  input  logic            alu_zero,
  output logic            halted,
  output logic            fault
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST =
    WC_W'(MEM_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [WC_W-1:0] wait_q, wait_d;

  op_class_e       cls;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] rt_pc;
  logic            is_load;
  logic            is_store;
  logic            fetch_go;

  seq_decode u_dec (
    .op  (ir_q[OP_HI:OP_LO]),
    .cls (cls)
  );

  assign is_load  = (cls == CL_LOAD);
  assign is_store = (cls == CL_STORE);
  assign rt_pc    = PC_W'(ir_q[RT_HI:RT_LO]);
  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_br    = pc_q + rt_pc;

`ifdef SEQ_STEP_EN
  assign fetch_go = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign fetch_go    = 1'b1;
`endif

  // next-state, pc, instruction register and wait counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = imem_data;
        if (imem_data[OP_HI:OP_LO] == OP_HALT)
          state_d = S_HALT;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        wait_d = '0;
        unique case (cls)
          CL_ALU:   state_d = S_WB;
          CL_LOAD,
          CL_STORE: state_d = S_MEM;
          CL_BRANCH: begin
            pc_d    = alu_zero ? pc_br : pc_inc;
            state_d = S_FETCH;
          end
          CL_JUMP: begin
            pc_d    = rt_pc;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_addr  = pc_q;
  assign opcode     = ir_q[OP_HI:OP_LO];
  assign read_reg1  = ir_q[RS_HI:RS_LO];
  assign read_reg2  = ir_q[RT_HI:RT_LO];
  assign write_reg  = ir_q[RD_HI:RD_LO];
  assign reg_write  = (state_q == S_WB);
  assign mem_to_reg = (state_q == S_WB) && is_load;
  assign mem_read   = (state_q == S_MEM) && is_load;
  assign mem_write  = (state_q == S_MEM) && is_store;
  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer.
// Behavioural ROM with one-cycle read latency.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  opcode;
  logic [3:0]  read_reg1;
  logic [3:0]  read_reg2;
  logic [3:0]  write_reg;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ack;
  logic        alu_zero;
  logic        halted;
  logic        fault;

  logic [15:0] rom [16];
  int errors;
  int checks;

  instr_sequencer #(.PC_W(4), .MEM_TIMEOUT(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_ack    (mem_ack),
    .alu_zero   (alu_zero),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial imem_data = 16'h0000;
  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'hE000;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    run      = 1'b0;
    step     = 1'b0;
    mem_ack  = 1'b0;
    alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    clear_rom();
    do_reset();
    o = {reg_write, mem_to_reg, mem_read,
         mem_write, halted, fault, 1'b0};
    checks++;
    if (o !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0", o);
    end
    checks++;
    if ({imem_addr, opcode} !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc_op: got %h exp 00",
               {imem_addr, opcode});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (imem_addr !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold: got %0d exp 0",
               imem_addr);
    end
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0] = 16'h0312;
    rom[1] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (imem_addr !== 4'd0) begin
          errors++;
          $display("FAIL alu_fetch: got %0d exp 0",
                   imem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if ({read_reg1, read_reg2, reg_write}
            !== {4'd1, 4'd2, 1'b0}) begin
          errors++;
          $display("FAIL alu_rr: got %h/%h/%b exp 1/2/0",
                   read_reg1, read_reg2, reg_write);
        end
      end
      if (c == 4) begin
        checks++;
        if ({reg_write, mem_to_reg, write_reg}
            !== {1'b1, 1'b0, 4'd3}) begin
          errors++;
          $display("FAIL alu_wb: got %b/%b/%0d exp 1/0/3",
                   reg_write, mem_to_reg, write_reg);
        end
      end
      if (c == 5) begin
        checks++;
        if ({imem_addr, reg_write} !== {4'd1, 1'b0}) begin
          errors++;
          $display("FAIL alu_pc: got %0d/%b exp 1/0",
                   imem_addr, reg_write);
        end
      end
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL alu_halt: got %b exp 1", halted);
    end
  endtask

  task automatic test_load();
    int cnt;
    int both;
    cnt  = 0;
    both = 0;
    clear_rom();
    rom[0] = 16'h4450;
    rom[1] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) cnt++;
      if (reg_write && (mem_read || mem_write)) both++;
      if (c == 3) begin
        checks++;
        if ({opcode, read_reg1} !== {4'd4, 4'd5}) begin
          errors++;
          $display("FAIL lw_dec: got %h/%h exp 4/5",
                   opcode, read_reg1);
        end
      end
      if (c == 7) begin
        checks++;
        if ({reg_write, mem_to_reg, write_reg, mem_read}
            !== {1'b1, 1'b1, 4'd4, 1'b0}) begin
          errors++;
          $display("FAIL lw_wb: got %b/%b/%0d/%b exp 1/1/4/0",
                   reg_write, mem_to_reg, write_reg,
                   mem_read);
        end
      end
      if (c == 8) begin
        checks++;
        if (imem_addr !== 4'd1) begin
          errors++;
          $display("FAIL lw_pc: got %0d exp 1", imem_addr);
        end
      end
      mem_ack = (c == 6);
    end
    mem_ack = 1'b0;
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL lw_rd_cycles: got %0d exp 3", cnt);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL lw_overlap: got %0d exp 0", both);
    end
  endtask

  task automatic test_store_timeout();
    int cnt;
    cnt = 0;
    clear_rom();
    rom[0] = 16'h5012;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (mem_write) cnt++;
      if (c == 10) begin
        checks++;
        if ({mem_write, fault} !== 2'b10) begin
          errors++;
          $display("FAIL sw_last: got %b exp 10",
                   {mem_write, fault});
        end
      end
      if (c == 11) begin
        checks++;
        if ({mem_write, fault} !== 2'b01) begin
          errors++;
          $display("FAIL sw_fault: got %b exp 01",
                   {mem_write, fault});
        end
      end
      mem_ack = (c >= 11);
    end
    mem_ack = 1'b0;
    checks++;
    if (cnt !== 7) begin
      errors++;
      $display("FAIL sw_wr_cycles: got %0d exp 7", cnt);
    end
    checks++;
    if ({fault, imem_addr} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL sw_sticky: got %b/%0d exp 1/0",
               fault, imem_addr);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL sw_clear: got %b exp 0", fault);
    end
  endtask

  task automatic test_branch(input logic z,
                             input logic [3:0] exp_pc);
    clear_rom();
    rom[0]  = 16'h700E;
    rom[14] = 16'h6003;
    rom[1]  = 16'hF000;
    rom[15] = 16'hF000;
    do_reset();
    alu_zero = z;
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (imem_addr !== 4'd14) begin
          errors++;
          $display("FAIL jmp_pc: got %0d exp 14",
                   imem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (imem_addr !== exp_pc) begin
          errors++;
          $display("FAIL beq_pc z=%b: got %0d exp %0d",
                   z, imem_addr, exp_pc);
        end
      end
    end
  endtask

  task automatic test_halt();
    int strb;
    strb = 0;
    clear_rom();
    rom[2] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 8) begin
        checks++;
        if (halted !== 1'b0) begin
          errors++;
          $display("FAIL halt_early: got %b exp 0",
                   halted);
        end
      end
      if (c >= 9 && (reg_write || mem_read || mem_write))
        strb++;
    end
    checks++;
    if ({halted, imem_addr} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL halt_state: got %b/%0d exp 1/2",
               halted, imem_addr);
    end
    checks++;
    if (strb !== 0) begin
      errors++;
      $display("FAIL halt_strobes: got %0d exp 0", strb);
    end
  endtask

  task automatic test_reset_mid_lw();
    clear_rom();
    rom[0] = 16'h7005;
    rom[5] = 16'h4450;
    do_reset();
    run = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if ({mem_read, imem_addr} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL mid_lw: got %b/%0d exp 1/5",
               mem_read, imem_addr);
    end
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_read, imem_addr} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL mid_lw_rst: got %b/%0d exp 0/0",
               mem_read, imem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_step();
    logic [3:0] exp_mid;
    logic       exp_halt;
`ifdef SEQ_STEP_EN
    exp_mid  = 4'd1;
    exp_halt = 1'b0;
`else
    exp_mid  = 4'd3;
    exp_halt = 1'b1;
`endif
    clear_rom();
    rom[3] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 12) begin
        checks++;
        if (imem_addr !== exp_mid) begin
          errors++;
          $display("FAIL step_mid: got %0d exp %0d",
                   imem_addr, exp_mid);
        end
      end
      step = (c == 5) || (c == 15) || (c == 25);
    end
    step = 1'b0;
    checks++;
    if ({halted, imem_addr} !== {exp_halt, 4'd3}) begin
      errors++;
      $display("FAIL step_end: got %b/%0d exp %b/3",
               halted, imem_addr, exp_halt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alu();
    test_load();
    test_store_timeout();
    test_branch(1'b1, 4'd1);
    test_branch(1'b0, 4'd15);
    test_halt();
    test_reset_mid_lw();
    test_step();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
